// File: rtl/sparse_decoder_if.sv
// rtl/sparse_decoder_if.sv - sparse pair input and dense element output bus for sparse_decoder
interface sparse_decoder_if #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8
);
  logic                  in_valid;
  logic                  in_ready;
  logic [ADDR_WIDTH-1:0] in_idx;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_last;
  logic                  out_valid;
  logic                  out_ready;
  logic [ADDR_WIDTH-1:0] out_addr;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_last;

  modport master (
    output in_valid, in_idx, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_addr, out_data, out_last
  );

  modport slave (
    input  in_valid, in_idx, in_data, in_last, out_ready,
    output in_ready, out_valid, out_addr, out_data, out_last
  );
endinterface

// File: rtl/sparse_decoder.sv
// rtl/sparse_decoder.sv - rebuilds a dense vector from (index, value) pairs and streams it out
// Optional nonzero counter port enabled by SPARSE_DECODER_NNZ_COUNT_EN.
module sparse_decoder #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            cs,
  sparse_decoder_if.slave bus,
  output logic            done,
  output logic            err
`ifdef SPARSE_DECODER_NNZ_COUNT_EN
  ,
  output logic [ADDR_WIDTH:0] nnz_count
`endif
);

  typedef enum logic [2:0] {IDLE, CLEAR, LOAD, DRAIN, DONE} state_t;

  localparam logic [ADDR_WIDTH:0] LAST_PTR = (ADDR_WIDTH+1)'(DEPTH - 1);
  localparam logic [ADDR_WIDTH:0] DEPTH_W  = (ADDR_WIDTH+1)'(DEPTH);

  state_t                state;
  logic [ADDR_WIDTH:0]   ptr;
  logic                  cs_q;
  logic [ADDR_WIDTH-1:0] prev_idx;
  logic                  prev_vld;
  logic                  in_ready_q;
  logic                  out_valid_q;
  logic                  out_last_q;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  start;
  logic                  in_hs;
  logic                  out_hs;
  logic                  idx_ok;
  logic                  idx_dup;
  logic [ADDR_WIDTH-1:0] rd_idx;

  assign start   = cs & ~cs_q;
  assign in_hs   = bus.in_valid & in_ready_q;
  assign out_hs  = out_valid_q & bus.out_ready;
  assign idx_ok  = {1'b0, bus.in_idx} < DEPTH_W;
  assign idx_dup = prev_vld & (bus.in_idx <= prev_idx);
  assign rd_idx  = ptr[ADDR_WIDTH-1:0];

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_last  = out_last_q;
  // Address/data are forced to zero outside DRAIN so idle outputs stay quiet.
  assign bus.out_addr  = out_valid_q ? rd_idx : '0;
  assign bus.out_data  = out_valid_q ? mem[rd_idx] : '0;

`ifdef SPARSE_DECODER_NNZ_COUNT_EN
  logic [ADDR_WIDTH:0] nnz_q;
  assign nnz_count = nnz_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      ptr         <= '0;
      cs_q        <= 1'b0;
      prev_idx    <= '0;
      prev_vld    <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
`ifdef SPARSE_DECODER_NNZ_COUNT_EN
      nnz_q       <= '0;
`endif
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      cs_q <= cs;
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state <= CLEAR;
            ptr   <= '0;
            err   <= 1'b0;
`ifdef SPARSE_DECODER_NNZ_COUNT_EN
            nnz_q <= '0;
`endif
          end
        end

        CLEAR: begin
          mem[rd_idx] <= '0;
          if (!cs) begin
            state <= IDLE;
          end else if (ptr == LAST_PTR) begin
            state      <= LOAD;
            ptr        <= '0;
            in_ready_q <= 1'b1;
            prev_vld   <= 1'b0;
          end else begin
            ptr <= ptr + 1'b1;
          end
        end

        LOAD: begin
          // The pair accepted in the cycle cs drops still lands in the array.
          if (in_hs) begin
            if (idx_ok) begin
              mem[bus.in_idx] <= bus.in_data;
            end
            if (!idx_ok || idx_dup) begin
              err <= 1'b1;
            end
            prev_idx <= bus.in_idx;
            prev_vld <= 1'b1;
`ifdef SPARSE_DECODER_NNZ_COUNT_EN
            if (idx_ok && (nnz_q != '1)) begin
              nnz_q <= nnz_q + 1'b1;
            end
`endif
          end
          if (!cs) begin
            state      <= IDLE;
            in_ready_q <= 1'b0;
          end else if (in_hs && bus.in_last) begin
            state       <= DRAIN;
            ptr         <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b1;
            out_last_q  <= (LAST_PTR == '0);
          end
        end

        DRAIN: begin
          if (!cs) begin
            state       <= IDLE;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
          end else if (out_hs) begin
            if (out_last_q) begin
              state       <= DONE;
              out_valid_q <= 1'b0;
              out_last_q  <= 1'b0;
              done        <= 1'b1;
            end else begin
              ptr        <= ptr + 1'b1;
              out_last_q <= ((ptr + 1'b1) == LAST_PTR);
            end
          end
        end

        DONE: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sparse_decoder.sv
// tb/tb_sparse_decoder.sv - directed self-checking bench for sparse_decoder (DEPTH 16 and 12)
module tb_sparse_decoder;
  localparam int AW = 4;
  localparam int DW = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          cs16, cs12;
  logic          in_valid, in_last, out_ready;
  logic [AW-1:0] in_idx;
  logic [DW-1:0] in_data;
  logic          done16, err16, done12, err12;
`ifdef SPARSE_DECODER_NNZ_COUNT_EN
  logic [AW:0]   nnz16, nnz12;
`endif

  sparse_decoder_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) b16 ();
  sparse_decoder_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) b12 ();

  assign b16.in_valid  = in_valid;
  assign b16.in_idx    = in_idx;
  assign b16.in_data   = in_data;
  assign b16.in_last   = in_last;
  assign b16.out_ready = out_ready;
  assign b12.in_valid  = in_valid;
  assign b12.in_idx    = in_idx;
  assign b12.in_data   = in_data;
  assign b12.in_last   = in_last;
  assign b12.out_ready = out_ready;

  sparse_decoder #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(16)) u_dut16 (
    .clk  (clk),
    .rst_n(rst_n),
    .cs   (cs16),
    .bus  (b16.slave),
    .done (done16),
    .err  (err16)
`ifdef SPARSE_DECODER_NNZ_COUNT_EN
    ,
    .nnz_count(nnz16)
`endif
  );

  sparse_decoder #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(12)) u_dut12 (
    .clk  (clk),
    .rst_n(rst_n),
    .cs   (cs12),
    .bus  (b12.slave),
    .done (done12),
    .err  (err12)
`ifdef SPARSE_DECODER_NNZ_COUNT_EN
    ,
    .nnz_count(nnz12)
`endif
  );

  int            n_checks = 0;
  int            n_fail   = 0;
  logic          use12;
  logic [DW-1:0] model [16];
  int            hs;

  logic          r_ready, r_valid, r_last, r_done, r_err;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_data;
  assign r_ready = use12 ? b12.in_ready  : b16.in_ready;
  assign r_valid = use12 ? b12.out_valid : b16.out_valid;
  assign r_last  = use12 ? b12.out_last  : b16.out_last;
  assign r_addr  = use12 ? b12.out_addr  : b16.out_addr;
  assign r_data  = use12 ? b12.out_data  : b16.out_data;
  assign r_done  = use12 ? done12 : done16;
  assign r_err   = use12 ? err12  : err16;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cs(input logic v);
    if (use12) cs12 = v;
    else cs16 = v;
  endtask

  task automatic clear_model();
    for (int i = 0; i < 16; i++) model[i] = '0;
  endtask

  task automatic start_frame(input logic sel);
    int n;
    use12 = sel;
    set_cs(1'b0);
    tick();
    set_cs(1'b1);
    n = 0;
    while (!r_ready && n < 60) begin
      tick();
      n++;
    end
    check("clear_len", n, (sel ? 12 : 16) + 1);
  endtask

  task automatic send(input logic [AW-1:0] idx, input logic [DW-1:0] data, input logic last);
    int n;
    in_valid = 1'b1;
    in_idx   = idx;
    in_data  = data;
    in_last  = last;
    n = 0;
    while (!r_ready && n < 100) begin
      tick();
      n++;
    end
    check("in_ready_wait", r_ready, 1'b1);
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // mode 0: out_ready held high; mode 1: out_ready toggles 1/0. abort_after>0 drops cs after that many handshakes.
  task automatic drain(input int mode, input int abort_after, input logic exp_err);
    int            depth;
    int            dones;
    logic          stalled;
    logic [AW-1:0] sa;
    logic [DW-1:0] sd;
    depth   = use12 ? 12 : 16;
    dones   = 0;
    stalled = 1'b0;
    sa      = '0;
    sd      = '0;
    hs      = 0;
    for (int cyc = 0; cyc < 200; cyc++) begin
      if (hs == depth || (abort_after > 0 && hs == abort_after)) break;
      out_ready = (mode == 1) ? (cyc % 2 == 0) : 1'b1;
      if (stalled) begin
        check("stall_valid", r_valid, 1'b1);
        check("stall_addr", r_addr, sa);
        check("stall_data", r_data, sd);
      end
      stalled = 1'b0;
      if (r_valid) begin
        if (out_ready) begin
          check("out_addr", r_addr, hs);
          check("out_data", r_data, model[hs]);
          check("out_last", r_last, hs == depth - 1);
          hs++;
        end else begin
          stalled = 1'b1;
          sa = r_addr;
          sd = r_data;
        end
      end
      tick();
      if (r_done) begin
        dones++;
        check("err_at_done", r_err, exp_err);
      end
    end
    if (abort_after > 0) begin
      set_cs(1'b0);
      tick();
      check("abort_out_valid", r_valid, 1'b0);
      check("abort_in_ready", r_ready, 1'b0);
      repeat (3) begin
        tick();
        if (r_done) dones++;
      end
      check("abort_no_done", dones, 0);
    end else begin
      check("hs_count", hs, depth);
      repeat (3) begin
        tick();
        if (r_done) dones++;
      end
      check("done_once", dones, 1);
      check("idle_valid", r_valid, 1'b0);
    end
    out_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    cs16 = 1'b0;
    cs12 = 1'b0;
    in_valid = 1'b0;
    in_last = 1'b0;
    in_idx = '0;
    in_data = '0;
    out_ready = 1'b0;
    use12 = 1'b0;
    clear_model();
    repeat (2) tick();
    check("rst_in_ready", b16.in_ready, 1'b0);
    check("rst_out_valid", b16.out_valid, 1'b0);
    check("rst_out_addr", b16.out_addr, 0);
    check("rst_out_data", b16.out_data, 0);
    check("rst_out_last", b16.out_last, 1'b0);
    check("rst_done", done16, 1'b0);
    check("rst_err", err16, 1'b0);
    rst_n = 1'b1;
    tick();

    // basic frame, free-flowing output
    clear_model();
    model[2] = 8'h11;
    model[5] = 8'h22;
    model[15] = 8'h33;
    start_frame(1'b0);
    send(4'd2, 8'h11, 1'b0);
    send(4'd5, 8'h22, 1'b0);
    send(4'd15, 8'h33, 1'b1);
    drain(0, 0, 1'b0);
    check("t1_err", err16, 1'b0);
`ifdef SPARSE_DECODER_NNZ_COUNT_EN
    check("t1_nnz", nnz16, 3);
`endif
    // cs still high: no restart without a fresh rising edge
    repeat (4) tick();
    check("no_restart_ready", b16.in_ready, 1'b0);
    check("no_restart_valid", b16.out_valid, 1'b0);

    // same frame with backpressure
    start_frame(1'b0);
    send(4'd2, 8'h11, 1'b0);
    send(4'd5, 8'h22, 1'b0);
    send(4'd15, 8'h33, 1'b1);
    drain(1, 0, 1'b0);

    // duplicate index: last write wins, err sticky
    clear_model();
    model[4] = 8'hBB;
    start_frame(1'b0);
    send(4'd4, 8'hAA, 1'b0);
    send(4'd4, 8'hBB, 1'b1);
    drain(0, 0, 1'b1);
    check("t3_err_after", err16, 1'b1);

    // next start clears err, then abort mid-drain
    clear_model();
    model[1] = 8'h10;
    model[3] = 8'h30;
    model[9] = 8'h90;
    start_frame(1'b0);
    check("t5_err_cleared", err16, 1'b0);
    send(4'd1, 8'h10, 1'b0);
    send(4'd3, 8'h30, 1'b0);
    send(4'd9, 8'h90, 1'b1);
    drain(0, 3, 1'b0);

    // fresh frame after abort: stale entries must be gone
    clear_model();
    model[0] = 8'h01;
    model[15] = 8'h0F;
    start_frame(1'b0);
    send(4'd0, 8'h01, 1'b0);
    send(4'd15, 8'h0F, 1'b1);
    drain(0, 0, 1'b0);

    // DEPTH 12: out-of-range index dropped
    clear_model();
    start_frame(1'b1);
    send(4'd13, 8'h55, 1'b1);
    drain(0, 0, 1'b1);
`ifdef SPARSE_DECODER_NNZ_COUNT_EN
    check("t4_nnz", nnz12, 0);
`endif
    use12 = 1'b0;

    // async reset mid-LOAD
    start_frame(1'b0);
    send(4'd7, 8'h99, 1'b0);
    check("pre_rst_ready", b16.in_ready, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_mid_ready", b16.in_ready, 1'b0);
    check("rst_mid_err", err16, 1'b0);
    cs16 = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    clear_model();
    model[0] = 8'h01;
    start_frame(1'b0);
    send(4'd0, 8'h01, 1'b1);
    drain(0, 0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sparse_decoder.md
Name: sparse_decoder

Overview:
- Receive end of the sparse-vector link driven by the encoder: accepts (index, value) pairs for nonzero elements and rebuilds the dense vector in a local register array.
- Then streams the dense vector out in ascending address order toward the tensor-core operand path.
- One frame per rising edge of cs.

Parameters:
- ADDR_WIDTH, 4, width of element index and output address.
- DATA_WIDTH, 8, element width.
- DEPTH, 16, dense vector length; must satisfy 1 <= DEPTH <= 2**ADDR_WIDTH.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- cs  input  1  chip select; rising edge starts a frame, low aborts one in progress.
- in_valid  input  1  pair valid.
- in_ready  output  1  decoder can accept a pair.
- in_idx  input  ADDR_WIDTH  element index.
- in_data  input  DATA_WIDTH  element value.
- in_last  input  1  final pair of frame.
- out_valid  output  1  dense element valid.
- out_ready  input  1  downstream accepts element.
- out_addr  output  ADDR_WIDTH  element address.
- out_data  output  DATA_WIDTH  element value.
- out_last  output  1  high with element DEPTH-1.
- done  output  1  one-cycle pulse after final output handshake.
- err  output  1  sticky protocol error for current frame.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; all outputs 0.
  - mem[] all 0; cs_q=0; pointers 0; prev-index-valid flag cleared.
- cs_q registers cs each cycle; start = cs & ~cs_q.
- FSM states: IDLE, CLEAR, LOAD, DRAIN, DONE.
- IDLE:
  - in_ready=0, out_valid=0.
  - start -> CLEAR; err cleared on this transition.
- CLEAR:
  - Writes mem[ptr]=0 for ptr=0..DEPTH-1, one entry per cycle (DEPTH cycles).
  - After ptr=DEPTH-1 -> LOAD, ptr reset to 0.
- LOAD:
  - in_ready=1. Handshake = in_valid & in_ready.
  - On handshake with in_idx<DEPTH: mem[in_idx]<=in_data; visible next cycle.
  - in_idx>=DEPTH: write dropped, err<=1.
  - in_idx <= previous accepted index in this frame (non-ascending or duplicate): write still performed (last wins), err<=1.
  - Handshake with in_last=1 -> DRAIN next cycle; ptr=0.
  - A frame with zero nonzeros is sent as a single pair carrying in_last; its write rules are unchanged.
- DRAIN:
  - in_ready=0, out_valid=1, out_addr=ptr, out_data=mem[ptr] (combinational from array), out_last=(ptr==DEPTH-1).
  - Outputs hold stable while out_ready=0.
  - Handshake advances ptr; handshake with out_last -> DONE.
- DONE: done=1 for exactly one cycle, then IDLE. cs held high does not restart; a new rising edge is required.
- Abort: cs=0 while in CLEAR/LOAD/DRAIN -> IDLE next cycle.
  - Handshake in that same cycle still takes effect.
  - No done pulse; err keeps its value.
- start while not IDLE: ignored.
- Async reset mid-frame: immediate return to reset values, including mem.
- ptr is ADDR_WIDTH+1 bits internally; no wrap inside a frame.

Optional Feature:
- SPARSE_DECODER_NNZ_COUNT_EN defined:
  - Adds output nnz_count [ADDR_WIDTH:0].
  - Cleared on entering CLEAR; increments on each LOAD handshake with in_idx<DEPTH; saturates at 2**(ADDR_WIDTH+1)-1; holds through DRAIN/DONE/IDLE.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Reset, cs rises; pairs (2,0x11),(5,0x22),(15,0x33,last), out_ready=1 -> CLEAR lasts 16 cycles; output addr 0..15 with data 0x11@2, 0x22@5, 0x33@15, 0 elsewhere; out_last only at addr 15; done pulses once; err=0.
- Same frame, out_ready toggled 1/0 each cycle -> out_addr/out_data stable while stalled; exactly 16 handshakes; done after the 16th.
- Pairs (4,0xAA),(4,0xBB,last) -> addr 4 reads 0xBB; err=1 through DONE; next frame start clears err.
- DEPTH=12, pair (13,0x55,last) -> no write, all 12 outputs 0, err=1; with SPARSE_DECODER_NNZ_COUNT_EN, nnz_count=0.
- cs dropped after 3 of 16 DRAIN handshakes -> IDLE next cycle, out_valid=0, no done. New cs rise runs CLEAR and a full fresh frame; stale data is gone.
- rst_n pulsed low mid-LOAD after writing (7,0x99) -> in_ready=0 immediately, mem cleared. Subsequent frame with only (0,0x01,last) outputs 0 at addr 7.
